i2s_tx_frame_sched: RTL

//  Sequences the I2S transmit datapath in the aud_mclk domain.
//  - Accepts stereo samples from an AXI-Stream: tid 0 = left, tid 1 = right.
//  - Stages one complete L/R pair ahead of the frame that will carry it.
//  - Divides aud_mclk to produce SCLK and derives LRCLK from it.
//  - Schedules MSB-first serialisation in I2S format: 32 SCLK slots per channel, 64 per frame.
//  - Flags underflow and channel-order errors.

---
 rtl/i2s_tx_frame_sched_pkg.sv | 13 +
 rtl/i2s_tx_frame_sched_sclk_gen.sv | 38 +++
 rtl/i2s_tx_frame_sched.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/i2s_tx_frame_sched_pkg.sv
// Shared types and sizing for the I2S transmit frame scheduler.
package i2s_tx_10xe_defines;

  localparam int AUD_WIDTH    = 24;
  localparam int SLOTS_PER_CH = 32;
  localparam int FRAME_SLOTS  = 2 * SLOTS_PER_CH;
  localparam int SLOT_W       = $clog2(FRAME_SLOTS);

  typedef enum logic [1:0] {SCHED_IDLE, SCHED_PRIME, SCHED_RUN} i2s_sched_state_e;

  typedef logic [AUD_WIDTH-1:0] aud_sample;

endpackage

// File: rtl/i2s_tx_frame_sched_sclk_gen.sv
// SCLK divider: a down-counter reloaded with max(div,1)-1 at terminal count,
// toggling SCLK there. The divider value is re-sampled at each terminal count.
module i2s_tx_sclk_gen #(
  parameter int DIV_WIDTH = 8
) (
  input  logic                 aud_mclk,
  input  logic                 aud_mrst,
  input  logic                 run,
  input  logic [DIV_WIDTH-1:0] cfg_sclk_div,
  output logic                 sclk,
  output logic                 rise_stb,
  output logic                 fall_stb
);

  logic [DIV_WIDTH-1:0] cnt;
  logic [DIV_WIDTH-1:0] reload;
  logic                 tc;

  always_comb begin
    reload = (cfg_sclk_div == '0) ? '0 : cfg_sclk_div - DIV_WIDTH'(1);
    tc       = run && (cnt == '0);
    rise_stb = tc && !sclk;
    fall_stb = tc && sclk;
  end

  always_ff @(posedge aud_mclk) begin
    if (aud_mrst || !run) begin
      cnt  <= reload;
      sclk <= 1'b0;
    end else if (tc) begin
      cnt  <= reload;
      sclk <= ~sclk;
    end else begin
      cnt <= cnt - DIV_WIDTH'(1);
    end
  end

endmodule

// File: rtl/i2s_tx_frame_sched.sv
// I2S transmit frame scheduler: stages L/R pairs from AXI-Stream and serialises
// them MSB-first. Optional macro I2S_TX_UNDERFLOW_CNT_EN adds a saturating underflow counter.
//
// state       | meaning
// SCHED_IDLE  | core disabled, outputs and staging cleared
// SCHED_PRIME | collecting the first L/R pair, SCLK held low
// SCHED_RUN   | SCLK running, frames serialised, next pair staged
module i2s_tx_frame_sched
  import i2s_tx_10xe_defines::*;
#(
  parameter int DIV_WIDTH = 8
) (
  input  logic                 aud_mclk,
  input  logic                 aud_mrst,
  input  logic                 cfg_enable,
  input  logic [DIV_WIDTH-1:0] cfg_sclk_div,
  input  logic [31:0]          s_axis_tdata,
  input  logic [2:0]           s_axis_tid,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  output logic                 i2s_sclk,
  output logic                 i2s_lrclk,
  output logic                 i2s_sdata,
  output logic                 busy,
  output logic                 underflow,
`ifdef I2S_TX_UNDERFLOW_CNT_EN
  output logic [15:0]          underflow_cnt,
`endif
  output logic                 tid_err
);

  i2s_sched_state_e  state, state_nxt;
  aud_sample         stg_l, stg_r, sh_l, sh_r, beat;
  logic              stg_l_vld, stg_r_vld, exp_r;
  logic [SLOT_W-1:0] slot, slot_nxt, ch_pos;
  logic              pair_full, fire, tid_ok, wrap, ch_nxt, data_slot;
  logic              load_prime, go_idle, rise_stb, fall_stb;
  logic              unused_bits;

  i2s_tx_sclk_gen #(.DIV_WIDTH(DIV_WIDTH)) u_sclk_gen (
    .aud_mclk     (aud_mclk),
    .aud_mrst     (aud_mrst),
    .run          (state == SCHED_RUN),
    .cfg_sclk_div (cfg_sclk_div),
    .sclk         (i2s_sclk),
    .rise_stb     (rise_stb),
    .fall_stb     (fall_stb)
  );

  always_comb begin
    beat          = s_axis_tdata[AUD_WIDTH+3:4];
    unused_bits   = ^{s_axis_tdata[31:AUD_WIDTH+4], s_axis_tdata[3:0], rise_stb};
    pair_full     = stg_l_vld && stg_r_vld;
    busy          = (state != SCHED_IDLE);
    s_axis_tready = cfg_enable && busy && !pair_full;
    fire          = s_axis_tvalid && s_axis_tready;
    tid_ok        = (s_axis_tid == {2'b00, exp_r});
    wrap          = fall_stb && (slot == SLOT_W'(FRAME_SLOTS - 1));
    slot_nxt      = wrap ? '0 : slot + SLOT_W'(1);
    ch_nxt        = (slot_nxt >= SLOT_W'(SLOTS_PER_CH));
    ch_pos        = ch_nxt ? slot_nxt - SLOT_W'(SLOTS_PER_CH) : slot_nxt;
    data_slot     = (ch_pos != '0) && (ch_pos <= SLOT_W'(AUD_WIDTH));
  end

  always_comb begin
    state_nxt = state;
    case (state)
      SCHED_IDLE:  if (cfg_enable) state_nxt = SCHED_PRIME;
      SCHED_PRIME: begin
        if (!cfg_enable)    state_nxt = SCHED_IDLE;
        else if (pair_full) state_nxt = SCHED_RUN;
      end
      SCHED_RUN:   if (wrap && !cfg_enable) state_nxt = SCHED_IDLE;
      default:     state_nxt = SCHED_IDLE;
    endcase
    load_prime = (state == SCHED_PRIME) && (state_nxt == SCHED_RUN);
    go_idle    = (state == SCHED_RUN) && (state_nxt == SCHED_IDLE);
  end

  always_ff @(posedge aud_mclk) begin
    if (aud_mrst) state <= SCHED_IDLE;
    else          state <= state_nxt;
  end

  // Staging never accepts a beat while full, so a wrap load and a beat are exclusive.
  always_ff @(posedge aud_mclk) begin
    if (aud_mrst) begin
      stg_l     <= '0;
      stg_r     <= '0;
      stg_l_vld <= 1'b0;
      stg_r_vld <= 1'b0;
      exp_r     <= 1'b0;
      tid_err   <= 1'b0;
    end else begin
      tid_err <= fire && !tid_ok;
      if (state_nxt == SCHED_IDLE || load_prime || (wrap && pair_full)) begin
        stg_l     <= '0;
        stg_r     <= '0;
        stg_l_vld <= 1'b0;
        stg_r_vld <= 1'b0;
        exp_r     <= 1'b0;
      end else if (fire && tid_ok) begin
        if (exp_r) begin
          stg_r     <= beat;
          stg_r_vld <= 1'b1;
        end else begin
          stg_l     <= beat;
          stg_l_vld <= 1'b1;
        end
        exp_r <= ~exp_r;
      end
    end
  end

  always_ff @(posedge aud_mclk) begin
    if (aud_mrst) begin
      sh_l      <= '0;
      sh_r      <= '0;
      slot      <= '0;
      i2s_lrclk <= 1'b0;
      i2s_sdata <= 1'b0;
      underflow <= 1'b0;
    end else begin
      underflow <= 1'b0;
      if (load_prime || go_idle) begin
        sh_l      <= load_prime ? stg_l : '0;
        sh_r      <= load_prime ? stg_r : '0;
        slot      <= '0;
        i2s_lrclk <= 1'b0;
        i2s_sdata <= 1'b0;
      end else if (fall_stb) begin
        slot      <= slot_nxt;
        i2s_lrclk <= ch_nxt;
        i2s_sdata <= 1'b0;
        if (wrap) begin
          sh_l      <= pair_full ? stg_l : '0;
          sh_r      <= pair_full ? stg_r : '0;
          underflow <= !pair_full;
        end else if (data_slot) begin
          if (ch_nxt) begin
            i2s_sdata <= sh_r[AUD_WIDTH-1];
            sh_r      <= {sh_r[AUD_WIDTH-2:0], 1'b0};
          end else begin
            i2s_sdata <= sh_l[AUD_WIDTH-1];
            sh_l      <= {sh_l[AUD_WIDTH-2:0], 1'b0};
          end
        end
      end
    end
  end

`ifdef I2S_TX_UNDERFLOW_CNT_EN
  always_ff @(posedge aud_mclk) begin
    if (aud_mrst)                                 underflow_cnt <= '0;
    else if (underflow && underflow_cnt != 16'hFFFF) underflow_cnt <= underflow_cnt + 16'd1;
  end
`endif

endmodule
